// File: rtl/hex_scroll_ctrl_pkg.sv
// Shared types and constants for the scrolling hex-digit display controller.
package hex_scroll_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScroll = 2'd1,
        StPause  = 2'd2
    } state_e;

    localparam int unsigned MAX_LEN       = 16;
    localparam int unsigned DIGITS        = 8;
    localparam logic [3:0]  BLANK_DEFAULT = 4'hF;

    // Increment modulo len without ever forming an index >= len (requires idx < len).
    function automatic logic [4:0] next_idx(input logic [4:0] idx, input logic [4:0] len);
        logic [4:0] inc;
        inc = idx + 5'd1;
        return (inc == len) ? 5'd0 : inc;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Scroll-step divider: counts 0..DIV-1 while enabled and pulses tick on the terminal count.
module tick_gen #(
    parameter int unsigned DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a 16-digit message buffer through an 8-digit window at one step per TICK_DIV cycles.
module hex_scroll_ctrl
    import hex_scroll_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter logic [3:0]  BLANK    = BLANK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic [4:0]            msg_len,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  busy,
    output logic                  wrap
);

    logic [3:0] msg_q [MAX_LEN];

    state_e              state_q, state_d;
    logic [4:0]          ptr_q, ptr_d;
    logic [4:0]          len_q, len_d;
    logic                wrap_q, wrap_d;
    logic                busy_q, busy_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;

    logic       start_ok;
    logic       run;
    logic       tick;
    logic [4:0] ptr_nxt;
    logic [4:0] idx [DIGITS];

    assign start_ok = start && (msg_len != 5'd0) && (msg_len <= 5'(MAX_LEN));
    assign run      = (state_q != StIdle) && !pause;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (stop || start_ok),
        .en    (run),
        .tick  (tick)
    );

    // Buffer has no reset; writes are blocked only while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            msg_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        ptr_nxt = next_idx(ptr_q, len_q);
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
        if (stop) begin
            state_d = StIdle;
            ptr_d   = 5'd0;
        end else if (start_ok) begin
            state_d = StScroll;
            ptr_d   = 5'd0;
            len_d   = msg_len;
        end else begin
            if (tick) begin
                ptr_d  = ptr_nxt;
                wrap_d = (ptr_nxt == 5'd0);
            end
            unique case (state_q)
                StScroll: if (pause)  state_d = StPause;
                StPause:  if (!pause) state_d = StScroll;
                default:  state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    // Window is built from the current registered state, so disp lags any change by one cycle.
    always_comb begin
        idx[0] = ptr_q;
        for (int k = 1; k < DIGITS; k++) begin
            idx[k] = next_idx(idx[k-1], len_q);
        end
        disp_d = {DIGITS{BLANK}};
        if (state_q != StIdle) begin
            for (int k = 0; k < DIGITS; k++) begin
                disp_d[4*(DIGITS-1-k) +: 4] = msg_q[idx[k][3:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 5'd0;
            len_q   <= 5'd0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            disp_q  <= {DIGITS{BLANK}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
        end
    end

    assign disp = disp_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule
